// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One DATA_W word per set; misses refill from memory via valid/ready request + response strobe.
module dm_cache_ctrl #(
  parameter int unsigned TAG_W  = 28,
  parameter int unsigned SET_W  = 2,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [TAG_W-1:0]  tag_in_i,
  input  logic [SET_W-1:0]  set_in_i,
  input  logic [OFF_W-1:0]  offset_in_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [OFF_W-1:0]  resp_offset_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int unsigned NumLines = 2 ** SET_W;
  localparam int unsigned AddrW    = TAG_W + SET_W + OFF_W;

  typedef enum logic [2:0] {
    StIdle, StCompare, StMemReq, StMemWait, StResp, StFlush
  } state_e;

  state_e              state_q, state_d;
  logic [NumLines-1:0] valid_q, valid_d;
  logic                we_q, we_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;

  // Tag/data storage carries no reset; only the valid bits qualify it.
  logic [TAG_W-1:0]    tag_arr_q  [NumLines];
  logic [DATA_W-1:0]   data_arr_q [NumLines];
  logic                line_we, tag_we, hit;
  logic [DATA_W-1:0]   line_wdata;

  assign hit = valid_q[set_q] && (tag_arr_q[set_q] == tag_q);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    we_d       = we_q;
    tag_d      = tag_q;
    set_d      = set_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
        end else if (req_valid_i) begin
          we_d    = req_we_i;
          tag_d   = tag_in_i;
          set_d   = set_in_i;
          off_d   = offset_in_i;
          wdata_d = req_wdata_i;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (hit) begin
          if (hit_q != '1) hit_d = hit_q + 1'b1;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
        end
        if (hit && !we_q) begin
          rdata_d = data_arr_q[set_q];
          state_d = StResp;
        end else begin
          state_d = StMemReq;
        end
        // Write hit updates the line; write miss leaves it untouched.
        line_we = hit && we_q;
      end
      StMemReq: begin
        if (mem_req_ready_i) state_d = we_q ? StResp : StMemWait;
      end
      StMemWait: begin
        if (mem_resp_valid_i) begin
          line_we          = 1'b1;
          tag_we           = 1'b1;
          line_wdata       = mem_rdata_i;
          rdata_d          = mem_rdata_i;
          valid_d[set_q]   = 1'b1;
          state_d          = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StFlush: begin
        valid_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= '0;
      we_q    <= 1'b0;
      tag_q   <= '0;
      set_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we) data_arr_q[set_q] <= line_wdata;
    if (tag_we)  tag_arr_q[set_q]  <= tag_q;
  end

  logic [AddrW-1:0] addr_full;
  assign addr_full = {tag_q, set_q, {OFF_W{1'b0}}};

  generate
    if (AddrW >= 32) begin : g_addr_trunc
      assign mem_addr_o = addr_full[31:0];
    end else begin : g_addr_ext
      assign mem_addr_o = {{(32 - AddrW){1'b0}}, addr_full};
    end
  endgenerate

  assign req_ready_o     = (state_q == StIdle) && !flush_i;
  assign resp_valid_o    = (state_q == StResp);
  assign resp_rdata_o    = (state_q == StResp && !we_q) ? rdata_q : '0;
  assign resp_offset_o   = off_q;
  assign mem_req_valid_o = (state_q == StMemReq);
  assign mem_we_o        = we_q;
  assign mem_wdata_o     = wdata_q;
  assign hit_count_o     = hit_q;
  assign miss_count_o    = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl; a 2-bit-counter twin shares all stimulus to test saturation.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_we, mem_req_ready, mem_resp_valid;
  logic [27:0] tag_in;
  logic [1:0]  set_in, offset_in;
  logic [31:0] req_wdata, mem_rdata;

  logic        req_ready, resp_valid, mem_req_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  resp_offset;
  logic [15:0] hit_count, miss_count;

  logic        s_req_ready, s_resp_valid, s_mem_req_valid, s_mem_we;
  logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_resp_offset, s_hit_count, s_miss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_we_i(req_we), .tag_in_i(tag_in), .set_in_i(set_in),
    .offset_in_i(offset_in), .req_wdata_i(req_wdata), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_offset_o(resp_offset), .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata),
    .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  dm_cache_ctrl #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(s_req_ready), .req_we_i(req_we), .tag_in_i(tag_in), .set_in_i(set_in),
    .offset_in_i(offset_in), .req_wdata_i(req_wdata), .resp_valid_o(s_resp_valid),
    .resp_rdata_o(s_resp_rdata), .resp_offset_o(s_resp_offset),
    .mem_req_valid_o(s_mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_we_o(s_mem_we),
    .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_resp_valid_i(mem_resp_valid),
    .mem_rdata_i(mem_rdata), .hit_count_o(s_hit_count), .miss_count_o(s_miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and play the memory side; reports what the memory saw and the response.
  task automatic xact(input logic we, input logic [27:0] tag, input logic [1:0] set,
                      input logic [1:0] off, input logic [31:0] wdata, input int req_wait,
                      input logic [31:0] mem_data, output logic saw_mem, output logic we_seen,
                      output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                      output logic stable, output int lat, output logic [31:0] rdata,
                      output logic [1:0] roff);
    logic hs, sent;
    int   waited;
    saw_mem = 0; we_seen = 0; addr_seen = '0; wdata_seen = '0; stable = 1;
    lat = -1; rdata = '0; roff = '0; hs = 0; sent = 0; waited = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; tag_in = tag; set_in = set; offset_in = off; req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; roff = resp_offset;
        break;
      end
      if (hs && !we && !sent) begin
        mem_resp_valid = 1; mem_rdata = mem_data; sent = 1;
      end
      if (mem_req_valid && !hs) begin
        if (!saw_mem) begin
          we_seen = mem_we; addr_seen = mem_addr; wdata_seen = mem_wdata;
        end else if (mem_we !== we_seen || mem_addr !== addr_seen || mem_wdata !== wdata_seen) begin
          stable = 0;
        end
        saw_mem = 1;
        if (waited >= req_wait) begin
          mem_req_ready = 1; hs = 1;
        end
        waited++;
      end
    end
    if (lat < 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  logic        sm, wes, stb, seen_resp;
  logic [31:0] adr, wds, rd;
  logic [1:0]  ro;
  int          lat;

  initial begin
    rst = 1; flush = 0; req_valid = 0; req_we = 0; mem_req_ready = 0; mem_resp_valid = 0;
    tag_in = '0; set_in = '0; offset_in = '0; req_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_offset", {30'd0, resp_offset}, 32'd0);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_counts", {hit_count, miss_count}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Cold read miss, refill with DEADBEEF.
    xact(0, 28'hFFFFFFF, 2'd2, 2'd2, '0, 0, 32'hDEADBEEF, sm, wes, adr, wds, stb, lat, rd, ro);
    check("miss1_count", {16'd0, miss_count}, 32'd1);
    check("miss1_mem_seen", {31'd0, sm}, 32'd1);
    check("miss1_mem_we", {31'd0, wes}, 32'd0);
    check("miss1_addr", adr, 32'hFFFFFFF8);
    check("miss1_rdata", rd, 32'hDEADBEEF);
    check("miss1_offset", {30'd0, ro}, 32'd2);
    check("miss1_lat", lat, 32'd4);

    // Same read hits.
    xact(0, 28'hFFFFFFF, 2'd2, 2'd2, '0, 0, 32'h0, sm, wes, adr, wds, stb, lat, rd, ro);
    check("hit1_count", {16'd0, hit_count}, 32'd1);
    check("hit1_no_mem", {31'd0, sm}, 32'd0);
    check("hit1_lat", lat, 32'd2);
    check("hit1_rdata", rd, 32'hDEADBEEF);

    // Write hit with 3 cycles of memory back-pressure.
    xact(1, 28'hFFFFFFF, 2'd2, 2'd2, 32'h12345678, 3, 32'h0, sm, wes, adr, wds, stb, lat, rd, ro);
    check("wr_hit_count", {16'd0, hit_count}, 32'd2);
    check("wr_mem_we", {31'd0, wes}, 32'd1);
    check("wr_mem_wdata", wds, 32'h12345678);
    check("wr_mem_addr", adr, 32'hFFFFFFF8);
    check("wr_stable", {31'd0, stb}, 32'd1);
    check("wr_lat", lat, 32'd6);
    check("wr_rdata_zero", rd, 32'd0);

    xact(0, 28'hFFFFFFF, 2'd2, 2'd2, '0, 0, 32'h0, sm, wes, adr, wds, stb, lat, rd, ro);
    check("hit2_count", {16'd0, hit_count}, 32'd3);
    check("hit2_no_mem", {31'd0, sm}, 32'd0);
    check("hit2_rdata", rd, 32'h12345678);

    // Write miss must not allocate.
    xact(1, 28'h0000001, 2'd1, 2'd0, 32'hA5A5A5A5, 0, 32'h0, sm, wes, adr, wds, stb, lat, rd, ro);
    check("wmiss_count", {16'd0, miss_count}, 32'd2);
    check("wmiss_addr", adr, 32'h00000014);
    check("wmiss_we", {31'd0, wes}, 32'd1);
    check("wmiss_lat", lat, 32'd3);
    xact(0, 28'h0000001, 2'd1, 2'd0, '0, 0, 32'h0BADF00D, sm, wes, adr, wds, stb, lat, rd, ro);
    check("noalloc_miss", {16'd0, miss_count}, 32'd3);
    check("noalloc_rdata", rd, 32'h0BADF00D);

    // Flush beats a same-cycle request.
    @(negedge clk);
    flush = 1; req_valid = 1; req_we = 0; tag_in = 28'hFFFFFFF; set_in = 2'd2; offset_in = 2'd2;
    #1 check("flush_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 0; req_valid = 0;
    @(negedge clk);
    check("flush_no_resp", {31'd0, resp_valid}, 32'd0);
    check("flush_idle_ready", {31'd0, req_ready}, 32'd1);
    xact(0, 28'hFFFFFFF, 2'd2, 2'd2, '0, 0, 32'hCAFEF00D, sm, wes, adr, wds, stb, lat, rd, ro);
    check("flush_miss2", {16'd0, miss_count}, 32'd4);
    check("flush_miss2_mem", {31'd0, sm}, 32'd1);
    xact(0, 28'h0000001, 2'd1, 2'd0, '0, 0, 32'h11112222, sm, wes, adr, wds, stb, lat, rd, ro);
    check("flush_miss1", {16'd0, miss_count}, 32'd5);
    check("sat_miss", {30'd0, s_miss_count}, 32'd3);
    check("sat_hit", {30'd0, s_hit_count}, 32'd3);
    check("hit_after_flush", {16'd0, hit_count}, 32'd3);

    // Reset while waiting for the refill.
    @(negedge clk);
    req_valid = 1; req_we = 0; tag_in = 28'h0000002; set_in = 2'd3; offset_in = 2'd1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("abort_memreq", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    rst = 1;
    #1 check("abort_counts", {hit_count, miss_count}, 32'd0);
    @(negedge clk);
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'h55555555;
    seen_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (resp_valid) seen_resp = 1;
    end
    check("abort_no_resp", {31'd0, seen_resp}, 32'd0);
    check("abort_idle", {31'd0, req_ready}, 32'd1);
    check("abort_counts2", {hit_count, miss_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits directly downstream of the address splitter and consumes its tag_memory/set_memory/offset_memory fields.
- Holds one DATA_W word per set, keeps tag/valid state, and refills misses from main memory over a valid/ready request plus response-valid interface.
- Keeps saturating hit and miss counters for performance checks.

Parameters:
TAG_W, 28, tag width (matches splitter tag_memory)
SET_W, 2, set index width; number of lines = 2**SET_W
OFF_W, 2, byte offset width; offset is passed through only and ignored for indexing
DATA_W, 32, word width
CNT_W, 16, width of the hit and miss counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  invalidate all lines; sampled only in IDLE
req_valid  input  1  CPU request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
tag_in  input  TAG_W  tag from splitter
set_in  input  SET_W  set from splitter
offset_in  input  OFF_W  byte offset from splitter
req_wdata  input  DATA_W  write data
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  read word; zero on write responses
resp_offset  output  OFF_W  registered offset_in, for downstream byte select
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  memory write
mem_addr  output  32  {tag, set, OFF_W'b0}
mem_wdata  output  DATA_W  write data to memory
mem_resp_valid  input  1  read data return strobe
mem_rdata  input  DATA_W  read data from memory
hit_count  output  CNT_W  saturating hit counter
miss_count  output  CNT_W  saturating miss counter

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - All valid bits cleared; state goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_offset=0.
  - mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit_count=0, miss_count=0.
  - Tag and data arrays are not reset.
- States: IDLE, COMPARE, MEM_REQ, MEM_WAIT, RESP, FLUSH.
- IDLE:
  - req_ready = ~flush; req_ready is 0 in all other states.
  - flush=1 goes to FLUSH, which clears every valid bit in one cycle and then returns to IDLE. flush wins over a same-cycle req_valid.
  - req_valid & req_ready latches we, tag, set, offset and wdata, then goes to COMPARE.
- COMPARE: hit = valid[set] & (tag_arr[set]==tag).
  - Read hit: hit_count+1, then RESP.
  - Read miss: miss_count+1, then MEM_REQ with mem_we=0.
  - Write hit: data_arr[set] <= wdata, hit_count+1, then MEM_REQ with mem_we=1.
  - Write miss: miss_count+1, then MEM_REQ with mem_we=1. The line is not allocated.
- MEM_REQ:
  - mem_req_valid=1; mem_addr, mem_we and mem_wdata are held stable until mem_req_ready=1.
  - On handshake: reads go to MEM_WAIT, writes go to RESP.
  - mem_req_valid drops in the cycle after the handshake.
- MEM_WAIT:
  - On mem_resp_valid: data_arr[set] <= mem_rdata, tag_arr[set] <= tag, valid[set] <= 1; latch the read word; go to RESP.
  - mem_resp_valid is ignored in every other state.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata = line word for reads, 0 for writes.
  - resp_offset = latched offset.
  - No backpressure on the response.
- Latency from accept edge to resp_valid:
  - Read hit: 2 cycles.
  - Read miss: 2 + memory request wait + memory response wait + 1.
  - Write: 2 + memory request wait + 1.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP.
- Counters saturate at all-ones and do not wrap.
- rst asserted mid-transaction (e.g. in MEM_WAIT) aborts it. No resp_valid is issued, and a later stray mem_resp_valid is ignored.
- Any TAG_W/SET_W combination is valid: mem_addr is the zero-extended concatenation, truncated to 32 bits.

Test Plan:
- Reset, then read tag=0xFFFFFFF, set=2, offset=2 (address 0xFFFFFFFA) → miss_count=1; mem_addr=0xFFFFFFF8 with mem_we=0; return mem_rdata=0xDEADBEEF → resp_valid pulse with resp_rdata=0xDEADBEEF and resp_offset=2.
- Repeat the same read → hit_count=1, no mem_req_valid, resp_valid exactly 2 cycles after the accept edge with rdata 0xDEADBEEF.
- Write 0x12345678 to the same address → hit_count=2; mem_req_valid with mem_we=1 and mem_wdata=0x12345678 held across 3 cycles of mem_req_ready=0; then read → hit returns 0x12345678.
- Write to set=1, tag=0x0000001 (miss) → mem write issued; a following read of that address misses (miss_count increments), proving no write-allocate.
- Assert flush in IDLE together with req_valid → req_ready=0, all lines invalid; the next read of 0xFFFFFFFA misses.
- Assert rst while in MEM_WAIT, then pulse mem_resp_valid → no resp_valid, counters=0, state IDLE. Separately force miss_count to 0xFFFF and issue a miss → stays 0xFFFF.
